// File: rtl/angle_disp_sched_if.sv
// Handshake/data bundle between the servo core (master) and the angle display scheduler (slave).
interface angle_disp_sched_if;
  logic       enable;
  logic [7:0] ang_ref;
  logic [7:0] ang_real;
  logic       upd;
  logic       busy;
  logic       valid;
  logic       digit_tick;
  logic [3:0] uni;
  logic [3:0] dec;
  logic [3:0] cent;
  logic [3:0] unir;
  logic [3:0] decr;
  logic [3:0] centr;

  modport master (
    output enable, ang_ref, ang_real, upd,
    input  busy, valid, digit_tick, uni, dec, cent, unir, decr, centr
  );

  modport slave (
    input  enable, ang_ref, ang_real, upd,
    output busy, valid, digit_tick, uni, dec, cent, unir, decr, centr
  );
endinterface

// File: rtl/angle_disp_sched.sv
// Angle-to-BCD scheduler for the seven-segment mux: shared serial double-dabble plus refresh tick.
// Optional AUTO_REFRESH_EN: every digit_tick also requests a conversion.
module angle_disp_sched #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned MAX_ANGLE   = 180
) (
  input logic               clk,
  input logic               rst_n,
  angle_disp_sched_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0] MAX_A = 8'(MAX_ANGLE);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_R  = 3'd1;
  localparam logic [2:0] SHIFT_R = 3'd2;
  localparam logic [2:0] LOAD_M  = 3'd3;
  localparam logic [2:0] SHIFT_M = 3'd4;
  localparam logic [2:0] COMMIT  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [7:0]       sh_q, sh_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [2:0]       bit_q, bit_d;
  logic [11:0]      ref_bcd_q, ref_bcd_d;
  logic             ref_oor_q, ref_oor_d;
  logic             real_oor_q, real_oor_d;
  logic [11:0]      disp_ref_q, disp_ref_d;
  logic [11:0]      disp_real_q, disp_real_d;
  logic [11:0]      adj_c;
  logic             trig_c;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj_c = dd_adjust(bcd_q);

`ifdef AUTO_REFRESH_EN
  assign trig_c = bus.upd | tick_q;
`else
  assign trig_c = bus.upd;
`endif

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    valid_d     = valid_q;
    sh_d        = sh_q;
    bcd_d       = bcd_q;
    bit_d       = bit_q;
    ref_bcd_d   = ref_bcd_q;
    ref_oor_d   = ref_oor_q;
    real_oor_d  = real_oor_q;
    disp_ref_d  = disp_ref_q;
    disp_real_d = disp_real_q;

    // Refresh divider: held at zero while the display is disabled.
    if (bus.enable) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    else            cnt_d = '0;
    tick_d = bus.enable && (cnt_d == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (trig_c || pend_q) begin
          state_d = LOAD_R;
          pend_d  = 1'b0;
        end
      end
      LOAD_R: begin
        sh_d      = bus.ang_ref;
        bcd_d     = '0;
        bit_d     = '0;
        ref_oor_d = bus.ang_ref > MAX_A;
        state_d   = SHIFT_R;
      end
      SHIFT_R: begin
        {bcd_d, sh_d} = {adj_c, sh_q} << 1;
        bit_d         = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = LOAD_M;
      end
      LOAD_M: begin
        ref_bcd_d  = bcd_q;
        sh_d       = bus.ang_real;
        bcd_d      = '0;
        bit_d      = '0;
        real_oor_d = bus.ang_real > MAX_A;
        state_d    = SHIFT_M;
      end
      SHIFT_M: begin
        {bcd_d, sh_d} = {adj_c, sh_q} << 1;
        bit_d         = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        disp_ref_d  = ref_oor_q  ? 12'hFFF : ref_bcd_q;
        disp_real_d = real_oor_q ? 12'hFFF : bcd_q;
        valid_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Requests arriving while busy (COMMIT included) merge into one pending slot.
    if (state_q != IDLE && trig_c) pend_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      sh_q        <= '0;
      bcd_q       <= '0;
      bit_q       <= '0;
      ref_bcd_q   <= '0;
      ref_oor_q   <= 1'b0;
      real_oor_q  <= 1'b0;
      disp_ref_q  <= '0;
      disp_real_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      sh_q        <= sh_d;
      bcd_q       <= bcd_d;
      bit_q       <= bit_d;
      ref_bcd_q   <= ref_bcd_d;
      ref_oor_q   <= ref_oor_d;
      real_oor_q  <= real_oor_d;
      disp_ref_q  <= disp_ref_d;
      disp_real_q <= disp_real_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.digit_tick = tick_q;
  assign bus.cent       = disp_ref_q[11:8];
  assign bus.dec        = disp_ref_q[7:4];
  assign bus.uni        = disp_ref_q[3:0];
  assign bus.centr      = disp_real_q[11:8];
  assign bus.decr       = disp_real_q[7:4];
  assign bus.unir       = disp_real_q[3:0];

endmodule

// File: tb/tb_angle_disp_sched.sv
// Self-checking bench for angle_disp_sched: directed scenarios plus random traffic vs a latency-level model.
module tb_angle_disp_sched;

  localparam int DIV = 4;
  localparam int MAXA = 180;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  angle_disp_sched_if bus();

  angle_disp_sched #(.REFRESH_DIV(DIV), .MAX_ANGLE(MAXA)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a conversion is a 19-edge window after the starting edge;
  // ref is sampled on window edge 1, real on edge 9 later, digits appear on edge 19.
  int          m_cnt = 0;
  bit          m_tick = 0;
  bit          m_active = 0;
  int          m_phase = 0;
  bit          m_pend = 0;
  bit          m_valid = 0;
  int          m_ref_s = 0;
  int          m_real_s = 0;
  logic [11:0] m_disp_ref = '0;
  logic [11:0] m_disp_real = '0;

  function automatic logic [11:0] to_bcd(input int v);
    if (v > MAXA) return 12'hFFF;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit trig;
    if (!rst_n) begin
      m_cnt = 0; m_tick = 0; m_active = 0; m_phase = 0; m_pend = 0; m_valid = 0;
      m_disp_ref = '0; m_disp_real = '0;
    end else begin
      trig = bus.upd;
`ifdef AUTO_REFRESH_EN
      trig = trig || m_tick;
`endif
      if (m_active) begin
        if (trig) m_pend = 1;
        m_phase++;
        if (m_phase == 1)  m_ref_s = int'(bus.ang_ref);
        if (m_phase == 10) m_real_s = int'(bus.ang_real);
        if (m_phase == 19) begin
          m_disp_ref  = to_bcd(m_ref_s);
          m_disp_real = to_bcd(m_real_s);
          m_valid     = 1;
          m_active    = 0;
        end
      end else if (trig || m_pend) begin
        m_active = 1; m_phase = 0; m_pend = 0;
      end
      m_cnt  = bus.enable ? (m_cnt + 1) % DIV : 0;
      m_tick = bus.enable && (m_cnt == DIV - 1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("busy",  bus.busy, m_active);
    check_eq("valid", bus.valid, m_valid);
    check_eq("tick",  bus.digit_tick, m_tick);
    check_eq("ref",   {bus.cent, bus.dec, bus.uni}, m_disp_ref);
    check_eq("real",  {bus.centr, bus.decr, bus.unir}, m_disp_real);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Pulse upd with given angles and wait out the 19-edge latency.
  task automatic run_conv(input int r, input int m, input string tag);
    bus.ang_ref = 8'(r); bus.ang_real = 8'(m); bus.upd = 1'b1;
    cycle();
    bus.upd = 1'b0;
    check_eq({tag, "_busy_start"}, bus.busy, 1);
    for (int i = 1; i < 19; i++) cycle();
    check_eq({tag, "_busy_last"}, bus.busy, 1);
    cycle();
    check_eq({tag, "_busy_end"}, bus.busy, 0);
    check_eq({tag, "_ref"},  {bus.cent, bus.dec, bus.uni}, to_bcd(r));
    check_eq({tag, "_real"}, {bus.centr, bus.decr, bus.unir}, to_bcd(m));
  endtask

  initial begin
    bus.enable = 1'b1; bus.ang_ref = '0; bus.ang_real = '0; bus.upd = 1'b0;

    do_reset();
    check_eq("rst_busy",  bus.busy, 0);
    check_eq("rst_valid", bus.valid, 0);
    check_eq("rst_tick",  bus.digit_tick, 0);
    check_eq("rst_digits", {bus.cent, bus.dec, bus.uni, bus.centr, bus.decr, bus.unir}, 0);

    // Refresh tick cadence, then disable/re-enable.
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check_eq("t5_tick", bus.digit_tick, (k % 4 == 3));
    end
    bus.enable = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check_eq("t5_off_tick", bus.digit_tick, 0);
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check_eq("t5_re_tick", bus.digit_tick, (k == 3));
    end

    bus.enable = 1'b0;
    do_reset();
    run_conv(123, 45, "t1");
    check_eq("t1_digits", {bus.cent, bus.dec, bus.uni, bus.centr, bus.decr, bus.unir}, 24'h123045);
    check_eq("t1_valid", bus.valid, 1);
    run_conv(200, 180, "t2");
    check_eq("t2_digits", {bus.cent, bus.dec, bus.uni, bus.centr, bus.decr, bus.unir}, 24'hFFF180);
    run_conv(5, 0, "t2z");
    check_eq("t2z_digits", {bus.cent, bus.dec, bus.uni, bus.centr, bus.decr, bus.unir}, 24'h005000);

    // Second upd while busy with a changed set-point.
    bus.ang_ref = 8'd10; bus.ang_real = 8'd1; bus.upd = 1'b1;
    cycle();
    bus.upd = 1'b0;
    for (int i = 1; i < 5; i++) cycle();
    bus.ang_ref = 8'd99; bus.upd = 1'b1;
    cycle();
    bus.upd = 1'b0;
    for (int i = 6; i <= 19; i++) cycle();
    check_eq("t3_first", {bus.cent, bus.dec, bus.uni}, 12'h010);
    check_eq("t3_gap_busy", bus.busy, 0);
    cycle();
    check_eq("t3_restart_busy", bus.busy, 1);
    for (int i = 21; i <= 39; i++) cycle();
    check_eq("t3_second", {bus.cent, bus.dec, bus.uni}, 12'h099);
    check_eq("t3_done_busy", bus.busy, 0);

    // Reset in the middle of a conversion.
    bus.ang_ref = 8'd50; bus.ang_real = 8'd60; bus.upd = 1'b1;
    cycle();
    bus.upd = 1'b0;
    for (int i = 1; i < 8; i++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_eq("t4_busy",  bus.busy, 0);
    check_eq("t4_valid", bus.valid, 0);
    check_eq("t4_digits", {bus.cent, bus.dec, bus.uni, bus.centr, bus.decr, bus.unir}, 0);
    run_conv(77, 150, "t4post");

    // Auto refresh without any upd.
    do_reset();
    bus.enable = 1'b1; bus.ang_ref = 8'd7; bus.ang_real = 8'd0;
    for (int i = 0; i < 59; i++) cycle();
`ifdef AUTO_REFRESH_EN
    check_eq("t6_auto", {bus.cent, bus.dec, bus.uni}, 12'h007);
`else
    check_eq("t6_auto", {bus.cent, bus.dec, bus.uni}, 12'h000);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 4))
        0:       bus.ang_ref = 8'd0;
        1:       bus.ang_ref = 8'($urandom_range(180, 181));
        default: bus.ang_ref = 8'($urandom_range(0, 255));
      endcase
      bus.ang_real = ($urandom_range(0, 4) == 0) ? 8'd255 : 8'($urandom_range(0, 200));
      bus.upd = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) bus.enable = ~bus.enable;
      rst_n = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
